// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, FSM states and constants for pipe_ctrl
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    // Bit i holds stage i: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_MC_BUSY = 2'd1,
        CTRL_FLUSH   = 2'd2
    } ctrl_state_t;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b0;

endpackage

// File: rtl/ctrl_mc_timer.sv
// rtl/ctrl_mc_timer.sv - loadable down-counter tracking remaining multi-cycle stall length
module ctrl_mc_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;

    // clr wins over load so an abort in the same cycle always leaves the timer idle
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush scheduler: flush > EX multi-cycle > ID load-use
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_stallreq,
    input  logic               ex_mc_start,
    input  logic [CNT_W-1:0]   ex_mc_cycles,
    input  logic               exc_req,
    input  logic [31:0]        exc_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               mc_done,
    output logic               mc_abort,
    output logic               busy,
    output logic [PERF_W-1:0]  stall_cnt
);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [CNT_W-1:0] eff_cycles;
    logic             eff_is_one;
    logic             tm_load;
    logic             tm_dec;
    logic             tm_clr;
    logic             tm_is_one;

    // A zero-length op still costs the cycle it was issued in
    assign eff_cycles = (ex_mc_cycles == '0) ? CNT_W'(1) : ex_mc_cycles;
    assign eff_is_one = (eff_cycles == CNT_W'(1));

    ctrl_mc_timer #(
        .CNT_W (CNT_W)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tm_load),
        .load_val (eff_cycles - CNT_W'(1)),
        .dec      (tm_dec),
        .clr      (tm_clr),
        .is_one   (tm_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= CTRL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = CTRL_IDLE;
        case (state)
            CTRL_IDLE: begin
                if (exc_req) begin
                    state_nxt = CTRL_FLUSH;
                end else if (ex_mc_start && !eff_is_one) begin
                    state_nxt = CTRL_MC_BUSY;
                end else begin
                    state_nxt = CTRL_IDLE;
                end
            end
            CTRL_MC_BUSY: begin
                if (exc_req) begin
                    state_nxt = CTRL_FLUSH;
                end else if (tm_is_one) begin
                    state_nxt = CTRL_IDLE;
                end else begin
                    state_nxt = CTRL_MC_BUSY;
                end
            end
            CTRL_FLUSH: state_nxt = CTRL_IDLE;
            default:    state_nxt = CTRL_IDLE;
        endcase
    end

    // Mealy outputs: a request raised this cycle takes effect this cycle
    always_comb begin
        stall    = STALL_W'(STALL_NONE);
        flush    = 1'b0;
        new_pc   = ZERO_WORD;
        mc_done  = 1'b0;
        mc_abort = 1'b0;
        busy     = 1'b0;
        tm_load  = 1'b0;
        tm_dec   = 1'b0;
        tm_clr   = 1'b0;
        if (rst != RST_ENABLE) begin
            busy = (state != CTRL_IDLE);
            case (state)
                CTRL_IDLE: begin
                    if (exc_req) begin
                        flush  = 1'b1;
                        new_pc = exc_pc;
                    end else if (ex_mc_start) begin
                        stall = STALL_W'(STALL_EX);
                        if (eff_is_one) begin
                            mc_done = 1'b1;
                        end else begin
                            tm_load = 1'b1;
                        end
                    end else if (id_stallreq) begin
                        stall = STALL_W'(STALL_ID);
                    end
                end
                CTRL_MC_BUSY: begin
                    if (exc_req) begin
                        flush    = 1'b1;
                        new_pc   = exc_pc;
                        mc_abort = 1'b1;
                        tm_clr   = 1'b1;
                    end else begin
                        stall   = STALL_W'(STALL_EX);
                        tm_dec  = 1'b1;
                        mc_done = tm_is_one;
                    end
                end
                CTRL_FLUSH: begin
                    // Requests seen here come from instructions being squashed
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stall_cnt <= '0;
        end else if (stall[0] && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl stall/flush scheduling
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stallreq = 1'b0;
    logic        ex_mc_start = 1'b0;
    logic [5:0]  ex_mc_cycles = 6'd0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_pc = 32'h0;

    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_done;
    logic        mc_abort;
    logic        busy;
    logic [31:0] stall_cnt;

    logic [5:0]  s_stall;
    logic        s_flush;
    logic [31:0] s_new_pc;
    logic        s_mc_done;
    logic        s_mc_abort;
    logic        s_busy;
    logic [3:0]  s_stall_cnt;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        mc_done;
        logic        mc_abort;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] perf_exp = 32'd0;
    logic [3:0]  perf_sat = 4'd0;

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_done      (mc_done),
        .mc_abort     (mc_abort),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    pipe_ctrl #(.PERF_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .exc_req      (exc_req),
        .exc_pc       (exc_pc),
        .stall        (s_stall),
        .flush        (s_flush),
        .new_pc       (s_new_pc),
        .mc_done      (s_mc_done),
        .mc_abort     (s_mc_abort),
        .busy         (s_busy),
        .stall_cnt    (s_stall_cnt)
    );

    // One clock: drive inputs, queue expected outputs, compare, advance the perf models
    task automatic step(input logic id, input logic st, input logic [5:0] cyc,
                        input logic exc, input logic [31:0] pc,
                        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                        input logic e_done, input logic e_abort, input logic e_busy,
                        input string tag);
        exp_t e;
        id_stallreq  = id;
        ex_mc_start  = st;
        ex_mc_cycles = cyc;
        exc_req      = exc;
        exc_pc       = pc;
        e.stall = e_stall; e.flush = e_flush; e.new_pc = e_pc;
        e.mc_done = e_done; e.mc_abort = e_abort; e.busy = e_busy; e.tag = tag;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        if (stall !== e.stall) begin
            errors++; $display("FAIL %s stall: got %b want %b", e.tag, stall, e.stall);
        end
        checks++;
        if (flush !== e.flush) begin
            errors++; $display("FAIL %s flush: got %b want %b", e.tag, flush, e.flush);
        end
        checks++;
        if (new_pc !== e.new_pc) begin
            errors++; $display("FAIL %s new_pc: got %h want %h", e.tag, new_pc, e.new_pc);
        end
        checks++;
        if (mc_done !== e.mc_done) begin
            errors++; $display("FAIL %s mc_done: got %b want %b", e.tag, mc_done, e.mc_done);
        end
        checks++;
        if (mc_abort !== e.mc_abort) begin
            errors++; $display("FAIL %s mc_abort: got %b want %b", e.tag, mc_abort, e.mc_abort);
        end
        checks++;
        if (busy !== e.busy) begin
            errors++; $display("FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
        end
        if (!rst) begin
            perf_exp = 32'd0;
            perf_sat = 4'd0;
        end else if (e.stall[0]) begin
            perf_exp = perf_exp + 32'd1;
            if (perf_sat != 4'hF) perf_sat = perf_sat + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1, 1, 6'd5, 1, 32'hDEAD_BEEF, 6'b0, 0, 32'h0, 0, 0, 0, "reset_hold");
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt);
        end
        rst = 1'b1;
        step(0, 0, 6'd0, 0, 32'h0, 6'b0, 0, 32'h0, 0, 0, 0, "reset_release");
        step(0, 0, 6'd0, 0, 32'h0, 6'b0, 0, 32'h0, 0, 0, 0, "reset_idle");
    endtask

    task automatic test_id_stall();
        step(1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, 0, "id_1");
        step(1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, 0, "id_2");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "id_release");
        checks++;
        if (stall_cnt !== 32'd2 || perf_exp !== 32'd2) begin
            errors++; $display("FAIL id stall_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_mc_five();
        step(1, 1, 6'd5, 0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, 0, "mc5_c1");
        for (int i = 2; i <= 4; i++)
            step(1, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, 1, "mc5_mid");
        step(1, 1, 6'd3, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, 1, "mc5_c5");
        step(1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, 0, "mc5_id_resume");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "mc5_idle");
        checks++;
        if (stall_cnt !== perf_exp) begin
            errors++; $display("FAIL mc5 stall_cnt: got %0d want %0d", stall_cnt, perf_exp);
        end
    endtask

    task automatic test_mc_short();
        step(0, 1, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, 0, "mc0");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "mc0_after");
        step(1, 1, 6'd1, 0, 32'h0, 6'b001111, 0, 32'h0, 1, 0, 0, "mc1");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "mc1_after");
    endtask

    task automatic test_abort();
        step(0, 1, 6'd8, 0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, 0, "abort_c1");
        step(1, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 32'h0, 0, 0, 1, "abort_c2");
        step(1, 0, 6'd0, 1, 32'h0000_0040, 6'b000000, 1, 32'h0000_0040, 0, 1, 1, "abort_c3");
        step(1, 1, 6'd4, 1, 32'h0000_0080, 6'b000000, 0, 32'h0, 0, 0, 1, "abort_bubble");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "abort_idle");
        // Exception from IDLE beats simultaneous EX and ID requests
        step(1, 1, 6'd4, 1, 32'h1234_5678, 6'b000000, 1, 32'h1234_5678, 0, 0, 0, "idle_exc");
        step(1, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 1, "idle_exc_bubble");
        step(1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, 0, "idle_exc_id");
    endtask

    task automatic test_saturate();
        rst = 1'b0;
        step(0, 0, 6'd0, 0, 32'h0, 6'b0, 0, 32'h0, 0, 0, 0, "sat_reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++)
            step(1, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 32'h0, 0, 0, 0, "sat_id");
        step(0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 32'h0, 0, 0, 0, "sat_idle");
        checks++;
        if (s_stall_cnt !== 4'hF || perf_sat !== 4'hF) begin
            errors++; $display("FAIL sat stall_cnt: got %h want f", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 32'd20) begin
            errors++; $display("FAIL wide stall_cnt: got %0d want 20", stall_cnt);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_id_stall();
        test_mc_five();
        test_mc_short();
        test_abort();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
